hack_mem_responder: RTL and testbench
=====================================

Name: hack_mem_responder

Overview:
- Responder end of the CPU data-memory interface.
- Accepts addressM, outM and writeM from the CPU and returns inM.
- Decodes the standard map: RAM 0x0000–0x3FFF, SCREEN 0x4000–0x5FFF, KBD 0x6000.
- Buffers screen writes in a FIFO toward the video side, latches keyboard codes, and asserts stall when a screen write cannot be accepted.

Parameters:
- RAM_AW, 14: RAM address width; RAM depth is 2^RAM_AW words.
- SCR_AW, 13: screen address width; shadow depth is 2^SCR_AW words.
- FIFO_DEPTH, 4: number of screen-write FIFO entries; must be a power of two and at least 2.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- addressM  in  16  CPU data address.
- outM  in  16  CPU write data.
- writeM  in  1  CPU write enable.
- inM  out  16  read data to CPU; combinational from addressM.
- stall  out  1  CPU must hold address, data and write and must not advance PC.
- scr_addr  out  13  head-of-FIFO screen word address.
- scr_data  out  16  head-of-FIFO screen data.
- scr_valid  out  1  FIFO not empty.
- scr_ready  in  1  video sink accepts the head entry.
- kbd_code  in  16  keyboard scan code.
- kbd_strobe  in  1  one-cycle pulse; kbd_code is valid.

Behaviour:
- Decode:
  - ram_sel = addressM[15:14]==2'b00.
  - scr_sel = addressM[15:13]==3'b010.
  - kbd_sel = addressM==16'h6000.
  - Any other address is unmapped: reads return 0 and writes are dropped silently.
- Reads, zero latency, combinational:
  - RAM selects ram[addressM[RAM_AW-1:0]].
  - SCREEN selects shadow[addressM[12:0]].
  - KBD selects kbd_reg.
- RAM write: on the rising edge when writeM & ram_sel. The new value is visible to a read on the next cycle.
- Screen write acceptance: scr_wr = writeM & scr_sel.
  - If scr_wr and the FIFO is not full, the edge writes shadow and pushes {addressM[12:0], outM}.
  - If scr_wr and the FIFO is full, stall=1 combinationally. No push and no shadow update occur. The write is accepted on the first edge after an entry has drained.
  - A full FIFO blocks the push even when a pop happens in the same cycle. There is no pass-through.
- FIFO:
  - Circular with wrap-around pointers and a count register, range 0..FIFO_DEPTH.
  - Pop on scr_valid & scr_ready.
  - Push and pop in the same cycle leave the count unchanged.
  - scr_valid is registered-output-stable: while valid=1 and ready=0, head data must not change.
  - Entries drain in FIFO order.
- stall is asserted only for a screen write into a full FIFO. Reads and RAM/KBD accesses never stall.
- KBD:
  - kbd_reg <= kbd_code on kbd_strobe.
  - CPU writes to 0x6000 are ignored.
- Reset (reset_n=0, asynchronous):
  - FIFO emptied: count=0, pointers=0, scr_valid=0.
  - kbd_reg=0, stall=0.
  - scr_addr and scr_data are 0 while empty.
  - RAM and shadow contents are not reset.
  - Reset during a stalled write discards that write.
  - Reset while the sink holds scr_ready discards all queued entries.

Optional Feature:
- Macro: KBD_CLEAR_ON_READ_EN.
- Defined:
  - A CPU read of 0x6000 with writeM=0 and stall=0 clears kbd_reg to 0 on that edge.
  - A kbd_strobe in the same cycle wins and loads kbd_code.
- Undefined: kbd_reg holds until the next strobe or reset.

Test Plan:
- RAM write/readback: write 16'h1234 to 0x0005; the next cycle reads 0x0005 → inM=16'h1234. Read 0x7000 → inM=0.
- Screen FIFO order, with scr_ready=0: write 0x4000←0xAAAA, then 0x5FFF←0x5555 → scr_valid=1, scr_addr=0, scr_data=0xAAAA. Reading 0x5FFF returns 0x5555. Raise ready → the next head is addr 0x1FFF, data 0x5555, then scr_valid=0.
- Full/stall, FIFO_DEPTH=4, ready=0: five consecutive screen writes → stall=1 on the 5th with count=4. Pulse ready for one cycle → the 5th write is accepted on the following edge, stall drops, and count=4.
- Keyboard: strobe with kbd_code=0x0041 → a read of 0x6000 returns 0x0041. A CPU write of 0x6000←0xFFFF leaves it at 0x0041. With KBD_CLEAR_ON_READ_EN, a second read returns 0; a strobe coincident with the read yields the new code.
- Reset mid-operation: with 3 queued entries and stall=0, assert reset_n=0 asynchronously mid-cycle → scr_valid=0 immediately and kbd_reg=0. After release, previously written RAM data is intact.

Source files
------------

// File: rtl/hack_mem_responder.sv
// -----------------------------------------------------------------------------
// hack_mem_responder
//
// Responder side of the Hack CPU data-memory interface. It decodes the
// standard memory map, serves zero-latency reads, owns the RAM and a screen
// shadow copy, latches keyboard codes, and forwards every accepted screen write
// to the video side through a small FIFO.
//
//   RAM     0x0000-0x3FFF  read/write, 2^RAM_AW words
//   SCREEN  0x4000-0x5FFF  read from the shadow, writes also queued to video
//   KBD     0x6000         read-only keyboard latch
//   other                  reads return 0, writes dropped
//
// Ports
//   clk        system clock, rising-edge
//   reset_n    asynchronous active-low reset
//   addressM   CPU data address
//   outM       CPU write data
//   writeM     CPU write enable
//   inM        read data to CPU, combinational from addressM
//   stall      CPU must hold address/data/write and not advance PC
//   scr_addr   head-of-FIFO screen word address (0 while empty)
//   scr_data   head-of-FIFO screen data (0 while empty)
//   scr_valid  FIFO not empty
//   scr_ready  video sink accepts the head entry
//   kbd_code   keyboard scan code
//   kbd_strobe one-cycle pulse qualifying kbd_code
//
// Build option
//   KBD_CLEAR_ON_READ_EN  when defined, a CPU read of 0x6000 (writeM=0,
//                         stall=0) clears the keyboard latch on that edge;
//                         a coincident kbd_strobe wins and loads the new code.
//
// Video handshake: an entry transfers on a rising edge where scr_valid and
// scr_ready are both 1. scr_valid never drops and scr_addr/scr_data never
// change while scr_valid=1 and scr_ready=0; scr_ready may be asserted
// regardless of scr_valid.
// -----------------------------------------------------------------------------
module hack_mem_responder #(
  parameter int RAM_AW     = 14,
  parameter int SCR_AW     = 13,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [15:0]       addressM,
  input  logic [15:0]       outM,
  input  logic              writeM,
  output logic [15:0]       inM,
  output logic              stall,
  output logic [SCR_AW-1:0] scr_addr,
  output logic [15:0]       scr_data,
  output logic              scr_valid,
  input  logic              scr_ready,
  input  logic [15:0]       kbd_code,
  input  logic              kbd_strobe
);

  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int CNT_W   = $clog2(FIFO_DEPTH + 1);
  localparam int ENTRY_W = SCR_AW + 16;

  // ---------------------------------------------------------------------------
  // Address decode
  // ---------------------------------------------------------------------------
  logic ram_sel;
  logic scr_sel;
  logic kbd_sel;

  always_comb begin
    ram_sel = (addressM[15:14] == 2'b00);
    scr_sel = (addressM[15:13] == 3'b010);
    kbd_sel = (addressM == 16'h6000);
  end

  // ---------------------------------------------------------------------------
  // Storage
  // ---------------------------------------------------------------------------
  logic [15:0] ram    [2**RAM_AW];
  logic [15:0] shadow [2**SCR_AW];
  logic [15:0] kbd_reg;

  // ---------------------------------------------------------------------------
  // Screen-write FIFO state
  // ---------------------------------------------------------------------------
  logic [ENTRY_W-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   head_ptr;
  logic [PTR_W-1:0]   tail_ptr;
  logic [CNT_W-1:0]   fifo_count;

  logic fifo_full;
  logic fifo_empty;
  logic scr_wr;
  logic push;
  logic pop;
  logic ram_we;

  always_comb begin
    fifo_full  = (fifo_count == CNT_W'(FIFO_DEPTH));
    fifo_empty = (fifo_count == '0);
    scr_wr     = writeM & scr_sel;
    // Fullness is judged on the registered count only: a pop in the same
    // cycle does not make room for the push (no pass-through path).
    push       = scr_wr & ~fifo_full;
    pop        = ~fifo_empty & scr_ready;
    stall      = scr_wr & fifo_full;
    ram_we     = writeM & ram_sel;
  end

  // ---------------------------------------------------------------------------
  // Combinational read mux
  // ---------------------------------------------------------------------------
  always_comb begin
    inM = 16'h0000;
    if (ram_sel) begin
      inM = ram[addressM[RAM_AW-1:0]];
    end else if (scr_sel) begin
      inM = shadow[addressM[SCR_AW-1:0]];
    end else if (kbd_sel) begin
      inM = kbd_reg;
    end
  end

  // ---------------------------------------------------------------------------
  // RAM and screen shadow writes (contents survive reset)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (ram_we) begin
      ram[addressM[RAM_AW-1:0]] <= outM;
    end
  end

  // The shadow only updates when the write is actually accepted into the
  // FIFO, so CPU read-back and the video stream always agree.
  always_ff @(posedge clk) begin
    if (push) begin
      shadow[addressM[SCR_AW-1:0]] <= outM;
    end
  end

  // ---------------------------------------------------------------------------
  // FIFO storage and pointers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[tail_ptr] <= {addressM[SCR_AW-1:0], outM};
    end
  end

  // Pointers wrap naturally because FIFO_DEPTH is a power of two.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      head_ptr <= '0;
      tail_ptr <= '0;
    end else begin
      if (push) begin
        tail_ptr <= tail_ptr + PTR_W'(1);
      end
      if (pop) begin
        head_ptr <= head_ptr + PTR_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fifo_count <= '0;
    end else begin
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CNT_W'(1);
        2'b01:   fifo_count <= fifo_count - CNT_W'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // Head outputs come straight from registered state; they are forced to zero
  // while empty so stale entries never appear on the bus.
  logic [ENTRY_W-1:0] head_entry;

  always_comb begin
    head_entry = fifo_mem[head_ptr];
    scr_valid  = ~fifo_empty;
    scr_addr   = '0;
    scr_data   = 16'h0000;
    if (!fifo_empty) begin
      scr_addr = head_entry[ENTRY_W-1:16];
      scr_data = head_entry[15:0];
    end
  end

  // ---------------------------------------------------------------------------
  // Keyboard latch (CPU writes to 0x6000 never reach it)
  // ---------------------------------------------------------------------------
`ifdef KBD_CLEAR_ON_READ_EN
  logic kbd_rd;

  always_comb begin
    kbd_rd = kbd_sel & ~writeM & ~stall;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      kbd_reg <= 16'h0000;
    end else if (kbd_strobe) begin
      kbd_reg <= kbd_code;
    end else if (kbd_rd) begin
      kbd_reg <= 16'h0000;
    end
  end
`else
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      kbd_reg <= 16'h0000;
    end else if (kbd_strobe) begin
      kbd_reg <= kbd_code;
    end
  end
`endif

endmodule

// File: tb/tb_hack_mem_responder.sv
// -----------------------------------------------------------------------------
// tb_hack_mem_responder
//
// Directed steps followed by a randomized phase, all in one initial block.
// Expected values come from a memory-map model built from arrays and a queue.
// -----------------------------------------------------------------------------
module tb_hack_mem_responder;

  localparam int DEPTH = 4;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic        clk = 1'b0;
  logic        reset_n;
  logic [15:0] addressM;
  logic [15:0] outM;
  logic        writeM;
  logic [15:0] inM;
  logic        stall;
  logic [12:0] scr_addr;
  logic [15:0] scr_data;
  logic        scr_valid;
  logic        scr_ready;
  logic [15:0] kbd_code;
  logic        kbd_strobe;

  always #5 clk = ~clk;

  hack_mem_responder #(.RAM_AW(14), .SCR_AW(13), .FIFO_DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .addressM   (addressM),
    .outM       (outM),
    .writeM     (writeM),
    .inM        (inM),
    .stall      (stall),
    .scr_addr   (scr_addr),
    .scr_data   (scr_data),
    .scr_valid  (scr_valid),
    .scr_ready  (scr_ready),
    .kbd_code   (kbd_code),
    .kbd_strobe (kbd_strobe)
  );

  // ---------------------------------------------------------------------------
  // Reference model: memory map as plain arrays, video FIFO as a queue
  // ---------------------------------------------------------------------------
  logic [15:0] ram_m    [0:16383];
  bit          ram_w    [0:16383];
  logic [15:0] shadow_m [0:8191];
  bit          scr_w    [0:8191];
  logic [15:0] kbd_m;
  logic [28:0] exp_q[$];

  int n_checks = 0;
  int n_pass   = 0;

  function automatic bit is_screen(input logic [15:0] a);
    return (a >= 16'h4000) && (a < 16'h6000);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Expected read value; known=0 when the location was never written.
  task automatic model_read(input logic [15:0] a, output logic [15:0] v, output bit known);
    known = 1'b1;
    v     = 16'h0000;
    if (a < 16'h4000) begin
      v     = ram_m[a - 16'h0000];
      known = ram_w[a];
    end else if (is_screen(a)) begin
      v     = shadow_m[a - 16'h4000];
      known = scr_w[a - 16'h4000];
    end else if (a == 16'h6000) begin
      v = kbd_m;
    end
  endtask

  task automatic compare_outputs();
    logic [15:0] v;
    bit          known;
    logic [28:0] head;
    int          sz;
    sz = exp_q.size();
    check("stall", {31'd0, stall}, {31'd0, writeM && is_screen(addressM) && sz == DEPTH});
    check("scr_valid", {31'd0, scr_valid}, {31'd0, sz != 0});
    head = (sz != 0) ? exp_q[0] : 29'd0;
    check("scr_addr", {19'd0, scr_addr}, {19'd0, head[28:16]});
    check("scr_data", {16'd0, scr_data}, {16'd0, head[15:0]});
    model_read(addressM, v, known);
    if (known) check("inM", {16'd0, inM}, {16'd0, v});
  endtask

  // ---------------------------------------------------------------------------
  // Driver tasks (called just after a falling edge)
  // ---------------------------------------------------------------------------
  task automatic drive(input logic [15:0] a, input logic [15:0] d, input logic w,
                       input logic rdy, input logic strb, input logic [15:0] code);
    addressM   = a;
    outM       = d;
    writeM     = w;
    scr_ready  = rdy;
    kbd_strobe = strb;
    kbd_code   = code;
    #1;
    compare_outputs();
  endtask

  // Advance one clock, applying the model's rules for the inputs now driven.
  task automatic tick();
    logic [15:0] a;
    logic [15:0] kn;
    int          sz;
    bit          pop;
    bit          push;
    a    = addressM;
    sz   = exp_q.size();
    pop  = (sz > 0) && scr_ready;
    push = writeM && is_screen(a) && (sz < DEPTH);
    kn   = kbd_m;
    if (kbd_strobe) kn = kbd_code;
`ifdef KBD_CLEAR_ON_READ_EN
    else if (a == 16'h6000 && !writeM) kn = 16'h0000;
`endif
    @(posedge clk);
    if (pop) void'(exp_q.pop_front());
    if (push) begin
      exp_q.push_back({a[12:0], outM});
      shadow_m[a - 16'h4000] = outM;
      scr_w[a - 16'h4000]    = 1'b1;
    end
    if (writeM && a < 16'h4000) begin
      ram_m[a] = outM;
      ram_w[a] = 1'b1;
    end
    kbd_m = kn;
    @(negedge clk);
  endtask

  task automatic idle(input logic rdy);
    drive(16'h7000, 16'h0000, 1'b0, rdy, 1'b0, 16'h0000);
    tick();
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    logic [15:0] ra;
    logic [15:0] rd;
    logic        rw;
    bit          hold;

    reset_n    = 1'b0;
    addressM   = 16'h7000;
    outM       = 16'h0000;
    writeM     = 1'b0;
    scr_ready  = 1'b0;
    kbd_code   = 16'h0000;
    kbd_strobe = 1'b0;
    kbd_m      = 16'h0000;

    // Reset state
    @(negedge clk);
    #1;
    check("rst_scr_valid", {31'd0, scr_valid}, 32'd0);
    check("rst_stall", {31'd0, stall}, 32'd0);
    check("rst_scr_addr", {19'd0, scr_addr}, 32'd0);
    check("rst_scr_data", {16'd0, scr_data}, 32'd0);
    check("rst_kbd", {16'd0, dut.kbd_reg}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // RAM write / readback, unmapped read
    drive(16'h0005, 16'h1234, 1'b1, 1'b0, 1'b0, 16'h0000); tick();
    drive(16'h0005, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000);
    check("ram_readback", {16'd0, inM}, 32'h1234);
    tick();
    drive(16'h7000, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000);
    check("unmapped_read", {16'd0, inM}, 32'h0);
    tick();
    drive(16'hFFFF, 16'hBEEF, 1'b1, 1'b0, 1'b0, 16'h0000); tick();
    drive(16'hFFFF, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000);
    check("unmapped_write_dropped", {16'd0, inM}, 32'h0);
    tick();

    // Screen FIFO order with the sink stalled
    drive(16'h4000, 16'hAAAA, 1'b1, 1'b0, 1'b0, 16'h0000); tick();
    drive(16'h5FFF, 16'h5555, 1'b1, 1'b0, 1'b0, 16'h0000); tick();
    drive(16'h5FFF, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000);
    check("scr_head_valid", {31'd0, scr_valid}, 32'd1);
    check("scr_head_addr", {19'd0, scr_addr}, 32'h0000);
    check("scr_head_data", {16'd0, scr_data}, 32'hAAAA);
    check("shadow_read", {16'd0, inM}, 32'h5555);
    tick();
    idle(1'b1);
    drive(16'h7000, 16'h0000, 1'b0, 1'b1, 1'b0, 16'h0000);
    check("scr_second_addr", {19'd0, scr_addr}, 32'h1FFF);
    check("scr_second_data", {16'd0, scr_data}, 32'h5555);
    tick();
    drive(16'h7000, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000);
    check("scr_drained", {31'd0, scr_valid}, 32'd0);
    tick();

    // Full FIFO and stall
    for (int i = 0; i < 4; i++) begin
      drive(16'h4010 + 16'(i), 16'h0100 + 16'(i), 1'b1, 1'b0, 1'b0, 16'h0000);
      tick();
    end
    drive(16'h4014, 16'h0104, 1'b1, 1'b0, 1'b0, 16'h0000);
    check("full_stall", {31'd0, stall}, 32'd1);
    check("full_count", {29'd0, dut.fifo_count}, 32'd4);
    tick();
    drive(16'h4014, 16'h0104, 1'b1, 1'b1, 1'b0, 16'h0000);
    check("stall_during_pop", {31'd0, stall}, 32'd1);
    tick();
    drive(16'h4014, 16'h0104, 1'b1, 1'b0, 1'b0, 16'h0000);
    check("stall_released", {31'd0, stall}, 32'd0);
    tick();
    drive(16'h4014, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000);
    check("refilled_count", {29'd0, dut.fifo_count}, 32'd4);
    check("refilled_shadow", {16'd0, inM}, 32'h0104);
    check("refilled_no_stall", {31'd0, stall}, 32'd0);
    tick();
    for (int i = 0; i < 5; i++) idle(1'b1);
    drive(16'h7000, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000);
    check("full_drained", {31'd0, scr_valid}, 32'd0);
    tick();

    // Keyboard latch
    drive(16'h7000, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h0041); tick();
    drive(16'h6000, 16'hFFFF, 1'b1, 1'b0, 1'b0, 16'h0000); tick();
    drive(16'h6000, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000);
    check("kbd_read", {16'd0, inM}, 32'h0041);
    tick();
    drive(16'h6000, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000);
`ifdef KBD_CLEAR_ON_READ_EN
    check("kbd_cleared", {16'd0, inM}, 32'h0000);
    tick();
    drive(16'h6000, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h0052); tick();
    drive(16'h6000, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000);
    check("kbd_strobe_wins", {16'd0, inM}, 32'h0052);
`else
    check("kbd_held", {16'd0, inM}, 32'h0041);
`endif
    tick();

    // Asynchronous reset mid-operation
    drive(16'h7000, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h0077); tick();
    for (int i = 0; i < 3; i++) begin
      drive(16'h4020 + 16'(i), 16'h0200 + 16'(i), 1'b1, 1'b0, 1'b0, 16'h0000);
      tick();
    end
    drive(16'h6000, 16'h0000, 1'b0, 1'b1, 1'b0, 16'h0000);
    check("pre_reset_valid", {31'd0, scr_valid}, 32'd1);
    #2 reset_n = 1'b0;
    #1;
    exp_q.delete();
    kbd_m = 16'h0000;
    check("async_reset_valid", {31'd0, scr_valid}, 32'd0);
    check("async_reset_kbd", {16'd0, inM}, 32'h0000);
    check("async_reset_stall", {31'd0, stall}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    drive(16'h0005, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000);
    check("ram_survives_reset", {16'd0, inM}, 32'h1234);
    tick();

    // Fill small windows so random reads hit known locations
    for (int i = 0; i < 16; i++) begin
      drive(16'(i), 16'($urandom_range(0, 65535)), 1'b1, 1'b1, 1'b0, 16'h0000);
      tick();
    end
    for (int i = 0; i < 8; i++) begin
      drive(16'h4000 + 16'(i), 16'($urandom_range(0, 65535)), 1'b1, 1'b1, 1'b0, 16'h0000);
      tick();
      drive(16'h5FF8 + 16'(i), 16'($urandom_range(0, 65535)), 1'b1, 1'b1, 1'b0, 16'h0000);
      tick();
    end
    for (int i = 0; i < 4; i++) idle(1'b1);

    // Randomized traffic; a stalled write is held until accepted
    hold = 1'b0;
    ra   = 16'h7000;
    rd   = 16'h0000;
    rw   = 1'b0;
    for (int n = 0; n < 600; n++) begin
      if (!hold) begin
        case ($urandom_range(0, 5))
          0, 1:    ra = 16'($urandom_range(0, 15));
          2:       ra = 16'h4000 + 16'($urandom_range(0, 7));
          3:       ra = 16'h5FF8 + 16'($urandom_range(0, 7));
          4:       ra = 16'h6000;
          default: ra = ($urandom_range(0, 1) == 0) ? 16'h7000 : 16'h6001;
        endcase
        rd = 16'($urandom_range(0, 65535));
        rw = ($urandom_range(0, 2) != 0);
      end
      drive(ra, rd, rw, ($urandom_range(0, 3) == 0), ($urandom_range(0, 7) == 0),
            16'($urandom_range(0, 65535)));
      hold = rw && is_screen(ra) && (exp_q.size() == DEPTH);
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
